// File: rtl/emmc_traffic_gen.sv
// Write/read pattern traffic generator and checker for the emmc_sm user port.
// Build option: define EMMC_TG_CHECK_EN to enable read compare and length check.
module emmc_traffic_gen #(
    parameter int unsigned BLK_CNT   = 1,
    parameter int unsigned BLK_BYTES = 512,
    parameter int unsigned PASSES    = 0,
    parameter int unsigned PATTERN   = 0,
    parameter logic [7:0]  SEED      = 8'h01
) (
    input  logic        clk_i,
    input  logic        arst_i,
    input  logic        start_i,
    input  logic        stop_i,
    output logic        we_o,
    output logic        start_o,
    output logic [15:0] blk_cnt_o,
    output logic [7:0]  dat_o,
    input  logic [7:0]  dat_i,
    input  logic        dvalid_i,
    input  logic        ready_i,
    output logic        busy_o,
    output logic        done_o,
    output logic [15:0] pass_cnt_o,
    output logic [15:0] err_cnt_o,
    output logic        mismatch_o
);

    localparam int unsigned TOTAL = BLK_CNT * BLK_BYTES;
    localparam int unsigned CNT_W = $clog2(TOTAL + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR_LAUNCH,
        S_WR_RUN,
        S_RD_LAUNCH,
        S_RD_RUN,
        S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic               start_q, start_d;
    logic               we_q, we_d;
    logic [7:0]         gen_q, gen_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               launched_q, launched_d;
    logic               stop_q, stop_d;
    logic [15:0]        pass_q, pass_d;
    logic [15:0]        err_q, err_d;
    logic               mis_q, mis_d;

    logic               xfer_end;
    logic               stop_now;
    logic [15:0]        pass_inc;
    logic [CNT_W-1:0]   cnt_step;

`ifdef EMMC_TG_CHECK_EN
    logic [1:0]         err_add;
    logic [16:0]        err_sum;
`else
    logic               unused_dat;
    assign unused_dat = ^dat_i;
`endif

    function automatic logic [7:0] next_byte(input logic [7:0] b);
        if (PATTERN == 0)
            return b + 8'd1;
        else
            return {b[6:0], b[7] ^ b[5] ^ b[4] ^ b[3]};
    endfunction

    function automatic logic [7:0] seed_for(input logic [7:0] p);
        logic [7:0] s;
        if (PATTERN == 0) begin
            s = SEED + p;
        end else begin
            s = SEED ^ p;
            if (s == 8'h00)
                s = 8'h01;
        end
        return s;
    endfunction

    assign xfer_end = launched_q & ready_i;
    assign pass_inc = pass_q + 16'd1;
    assign cnt_step = cnt_q + CNT_W'(dvalid_i);
    assign stop_now = stop_q | stop_i |
                      ((PASSES != 0) && (pass_inc == 16'(PASSES)));

    // State register
    always_ff @(posedge clk_i) begin
        if (arst_i)
            state_q <= S_IDLE;
        else
            state_q <= state_d;
    end

    // Next-state logic: launch waits for ready, run ends on ready after busy
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE, S_DONE: begin
                if (start_i)
                    state_d = S_WR_LAUNCH;
            end
            S_WR_LAUNCH: begin
                if (ready_i)
                    state_d = S_WR_RUN;
            end
            S_WR_RUN: begin
                if (xfer_end)
                    state_d = S_RD_LAUNCH;
            end
            S_RD_LAUNCH: begin
                if (ready_i)
                    state_d = S_RD_RUN;
            end
            S_RD_RUN: begin
                if (xfer_end)
                    state_d = stop_now ? S_DONE : S_WR_LAUNCH;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Output and datapath next values: generator, counters, compare
    always_comb begin
        start_d    = 1'b0;
        we_d       = we_q;
        gen_d      = gen_q;
        cnt_d      = cnt_q;
        launched_d = launched_q;
        stop_d     = stop_q;
        pass_d     = pass_q;
        err_d      = err_q;
        mis_d      = 1'b0;
        busy_o     = (state_q != S_IDLE) && (state_q != S_DONE);
        done_o     = (state_q == S_DONE);

        // Direction settles on entry to launch, a cycle before start_o
        if (state_d == S_WR_LAUNCH)
            we_d = 1'b1;
        else if (state_d == S_RD_LAUNCH)
            we_d = 1'b0;

        unique case (state_q)
            S_IDLE, S_DONE: begin
                if (start_i) begin
                    pass_d = '0;
                    err_d  = '0;
                    stop_d = 1'b0;
                end
            end
            S_WR_LAUNCH, S_RD_LAUNCH: begin
                if (stop_i)
                    stop_d = 1'b1;
                if (ready_i) begin
                    start_d    = 1'b1;
                    gen_d      = seed_for(pass_q[7:0]);
                    cnt_d      = '0;
                    launched_d = 1'b0;
                end
            end
            S_WR_RUN, S_RD_RUN: begin
                if (stop_i)
                    stop_d = 1'b1;
                if (!ready_i)
                    launched_d = 1'b1;
                if (dvalid_i) begin
                    gen_d = next_byte(gen_q);
                    cnt_d = cnt_step;
                end
                if ((state_q == S_RD_RUN) && xfer_end)
                    pass_d = pass_inc;
            end
            default: ;
        endcase

`ifdef EMMC_TG_CHECK_EN
        err_add = 2'd0;
        err_sum = 17'd0;
        if ((state_q == S_RD_RUN) && dvalid_i && (dat_i != gen_q)) begin
            mis_d   = 1'b1;
            err_add = err_add + 2'd1;
        end
        if (((state_q == S_WR_RUN) || (state_q == S_RD_RUN)) &&
            xfer_end && (cnt_step != CNT_W'(TOTAL)))
            err_add = err_add + 2'd1;
        if (err_add != 2'd0) begin
            err_sum = {1'b0, err_q} + {15'd0, err_add};
            err_d   = err_sum[16] ? 16'hFFFF : err_sum[15:0];
        end
`else
        err_d = '0;
`endif
    end

    // Datapath registers
    always_ff @(posedge clk_i) begin
        if (arst_i) begin
            start_q    <= 1'b0;
            we_q       <= 1'b1;
            gen_q      <= SEED;
            cnt_q      <= '0;
            launched_q <= 1'b0;
            stop_q     <= 1'b0;
            pass_q     <= '0;
            err_q      <= '0;
            mis_q      <= 1'b0;
        end else begin
            start_q    <= start_d;
            we_q       <= we_d;
            gen_q      <= gen_d;
            cnt_q      <= cnt_d;
            launched_q <= launched_d;
            stop_q     <= stop_d;
            pass_q     <= pass_d;
            err_q      <= err_d;
            mis_q      <= mis_d;
        end
    end

    assign we_o       = we_q;
    assign start_o    = start_q;
    assign blk_cnt_o  = 16'(BLK_CNT);
    assign dat_o      = gen_q;
    assign pass_cnt_o = pass_q;
    assign err_cnt_o  = err_q;
    assign mismatch_o = mis_q;

endmodule
